// File: rtl/div_iter_pkg.sv
// Shared defines for the integer execution unit: ALU op codes, divider FSM states
// and the default operand width.
package div_iter_pkg;

    localparam int unsigned DivWidth = 32;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOr,
        AluXor,
        AluSll,
        AluSrl,
        AluSra,
        AluSlt,
        AluSltu,
        DivStart,
        DivStop
    } alu_op_e;

    typedef enum logic [1:0] {
        DivIdle,
        DivBusy,
        DivDzero,
        DivDone
    } div_state_e;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor
// when it fits, and report the quotient bit.
module div_step #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] rem,
    input  logic         dvd_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // One extra bit: the shifted remainder can reach 2*divisor-1, which may exceed W bits.
    always_comb begin
        shifted  = {rem, dvd_bit};
        diff     = shifted - {1'b0, divisor};
        q_bit    = ~diff[W];
        rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
    end

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider (DIV/DIVU), one quotient bit per cycle, with annul
// and a zero-divisor fast path. result = {remainder, quotient}.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned W  = DivWidth,
    parameter int unsigned CW = $clog2(W) + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           signed_div,
    input  logic [W-1:0]   dividend,
    input  logic [W-1:0]   divisor,
    input  logic           annul,
    output logic [2*W-1:0] result,
    output logic           ready,
    output logic           div_zero,
    output logic           busy
);

    div_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [W-1:0]   dvd_q, dvd_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic           negq_q, negq_d;
    logic           negr_q, negr_d;
    logic [2*W-1:0] result_q, result_d;
    logic           div_zero_q, div_zero_d;

    logic [W-1:0]   step_rem;
    logic           step_q;
    logic [W-1:0]   quo_next;

    div_step #(
        .W(W)
    ) u_step (
        .rem     (rem_q),
        .dvd_bit (dvd_q[W-1]),
        .divisor (dvs_q),
        .rem_next(step_rem),
        .q_bit   (step_q)
    );

    // Dividend register doubles as the quotient register as bits shift out.
    assign quo_next = {dvd_q[W-2:0], step_q};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        negq_d     = negq_q;
        negr_d     = negr_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;

        unique case (state_q)
            DivIdle: begin
                if (start && !annul) begin
                    dvd_d   = (signed_div && dividend[W-1]) ? -dividend : dividend;
                    dvs_d   = (signed_div && divisor[W-1]) ? -divisor : divisor;
                    negq_d  = signed_div & (dividend[W-1] ^ divisor[W-1]);
                    negr_d  = signed_div & dividend[W-1];
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = (divisor == '0) ? DivDzero : DivBusy;
                end
            end
            DivBusy: begin
                if (annul) begin
                    state_d = DivIdle;
                end else begin
                    rem_d = step_rem;
                    dvd_d = quo_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(W - 1)) begin
                        state_d    = DivDone;
                        result_d   = {negr_q ? -step_rem : step_rem,
                                      negq_q ? -quo_next : quo_next};
                        div_zero_d = 1'b0;
                    end
                end
            end
            DivDzero: begin
                if (annul) begin
                    state_d = DivIdle;
                end else begin
                    // Undo the magnitude conversion to return the dividend as issued.
                    state_d    = DivDone;
                    result_d   = {negr_q ? -dvd_q : dvd_q, {W{1'b1}}};
                    div_zero_d = 1'b1;
                end
            end
            DivDone: begin
                state_d = DivIdle;
            end
            default: begin
                state_d = DivIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= DivIdle;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            negq_q     <= 1'b0;
            negr_q     <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            negq_q     <= negq_d;
            negr_q     <= negr_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign result   = result_q;
    assign div_zero = div_zero_q;
    assign ready    = (state_q == DivDone) && !annul;
    assign busy     = !rst && (((state_q == DivIdle) && start && !annul) ||
                               (state_q == DivBusy) || (state_q == DivDzero));

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: unsigned/signed divides, overflow, zero divisor,
// annul, reset mid-operation and back-to-back starts.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        div_zero;
    logic        busy;

    int checks = 0;
    int errors = 0;

    div_iter #(
        .W(32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_div(signed_div),
        .dividend  (dividend),
        .divisor   (divisor),
        .annul     (annul),
        .result    (result),
        .ready     (ready),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with the DUT idle. Issues start in cycle 0 and
    // returns in the ready cycle (or after a bounded wait), recording latency.
    task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [63:0] res, output logic dz,
                           output logic busy_ok);
        busy_ok    = 1'b1;
        lat        = -1;
        signed_div = sd;
        dividend   = a;
        divisor    = b;
        start      = 1'b1;
        #1;
        if (!busy) busy_ok = 1'b0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (ready) lat = c;
            else if (!busy) busy_ok = 1'b0;
        end
        res = result;
        dz  = div_zero;
    endtask

    int          lat;
    logic [63:0] res;
    logic        dz;
    logic        bok;
    logic        no_ready;

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        dividend   = '0;
        divisor    = '0;
        annul      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", result, 64'h0);
        check("reset_ready", {63'h0, ready}, 64'h0);
        check("reset_dz", {63'h0, div_zero}, 64'h0);
        check("reset_busy", {63'h0, busy}, 64'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 100 / 7 unsigned
        run_div(1'b0, 32'd100, 32'd7, lat, res, dz, bok);
        check("udiv_lat", 64'(lat), 64'd33);
        check("udiv_res", res, {32'd2, 32'd14});
        check("udiv_dz", {63'h0, dz}, 64'h0);
        check("udiv_busy_0_32", {63'h0, bok}, 64'h1);
        check("udiv_busy_done", {63'h0, busy}, 64'h0);
        @(posedge clk);
        #1;
        check("udiv_ready_pulse", {63'h0, ready}, 64'h0);

        // -100 / 7 signed
        run_div(1'b1, 32'hFFFF_FF9C, 32'd7, lat, res, dz, bok);
        check("sdiv_lat", 64'(lat), 64'd33);
        check("sdiv_res", res, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        @(posedge clk);
        #1;

        // 100 / -7 signed: remainder takes the dividend's sign
        run_div(1'b1, 32'd100, 32'hFFFF_FFF9, lat, res, dz, bok);
        check("sdiv2_res", res, {32'd2, 32'hFFFF_FFF2});
        @(posedge clk);
        #1;

        // 0xFFFFFFFF / 2 unsigned
        run_div(1'b0, 32'hFFFF_FFFF, 32'd2, lat, res, dz, bok);
        check("udiv_big_res", res, {32'd1, 32'h7FFF_FFFF});
        @(posedge clk);
        #1;

        // Signed overflow: most-negative / -1
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, dz, bok);
        check("ovf_lat", 64'(lat), 64'd33);
        check("ovf_res", res, {32'd0, 32'h8000_0000});
        check("ovf_dz", {63'h0, dz}, 64'h0);
        @(posedge clk);
        #1;

        // Annul in cycle 10 of 1000 / 3
        no_ready   = 1'b1;
        signed_div = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        start      = 1'b1;
        #1;
        check("annul_busy_c0", {63'h0, busy}, 64'h1);
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (ready) no_ready = 1'b0;
        end
        annul = 1'b1;
        @(posedge clk);
        #1;
        annul = 1'b0;
        if (ready) no_ready = 1'b0;
        check("annul_no_ready", {63'h0, no_ready}, 64'h1);
        check("annul_idle_busy", {63'h0, busy}, 64'h0);
        check("annul_result_kept", result, {32'd0, 32'h8000_0000});
        @(posedge clk);
        #1;
        run_div(1'b0, 32'd12345, 32'd100, lat, res, dz, bok);
        check("post_annul_lat", 64'(lat), 64'd33);
        check("post_annul_res", res, {32'd45, 32'd123});
        @(posedge clk);
        #1;

        // 55 / 0
        run_div(1'b0, 32'd55, 32'd0, lat, res, dz, bok);
        check("dz_lat", 64'(lat), 64'd2);
        check("dz_flag", {63'h0, dz}, 64'h1);
        check("dz_res", res, {32'd55, 32'hFFFF_FFFF});
        check("dz_busy", {63'h0, bok}, 64'h1);
        @(posedge clk);
        #1;

        // Reset in cycle 5 of 7 / 2
        signed_div = 1'b0;
        dividend   = 32'd7;
        divisor    = 32'd2;
        start      = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_result", result, 64'h0);
        check("rst_dz", {63'h0, div_zero}, 64'h0);
        check("rst_ready", {63'h0, ready}, 64'h0);
        start = 1'b1;
        #1;
        check("rst_busy_gated", {63'h0, busy}, 64'h0);
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        #1;
        check("rst_idle_busy", {63'h0, busy}, 64'h0);

        // First start after reset, then a start held through DONE
        run_div(1'b0, 32'd17, 32'd5, lat, res, dz, bok);
        check("b2b_first_lat", 64'(lat), 64'd33);
        check("b2b_first_res", res, {32'd2, 32'd3});
        dividend = 32'd9;
        divisor  = 32'd4;
        start    = 1'b1;
        #1;
        check("b2b_done_busy", {63'h0, busy}, 64'h0);
        @(posedge clk);
        #1;
        check("b2b_idle_busy", {63'h0, busy}, 64'h1);
        run_div(1'b0, 32'd9, 32'd4, lat, res, dz, bok);
        check("b2b_second_lat", 64'(lat), 64'd33);
        check("b2b_second_res", res, {32'd1, 32'd2});
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
